reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 106 ++++++++++
 tb/tb_reset_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged SoC reset (peripherals first, then CPU) from boot reset,
// a debounced push-button or a software request, with the last reset cause latched.
module reset_sequencer #(
    parameter int HOLD_CYCLES     = 20,
    parameter int STAGE_DELAY     = 16,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    input  logic       soft_reset_req,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic [1:0] reset_cause,
    output logic       reset_active
);
    localparam int MX = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int CW = $clog2(MX + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [1:0] {HOLD, REL_PERIPH, RUN, WAIT_RELEASE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] db_q, db_d;
    logic [1:0]    sync_q;
    logic [1:0]    cause_q, cause_d;
    logic          stable_q, stable_d;
    logic          periph_q, cpu_q;
    logic          differ, db_done, press;
    always_comb begin
        differ   = sync_q[1] != stable_q;
        db_done  = differ && db_q == DW'(DEBOUNCE_CYCLES - 1);
        stable_d = db_done ? sync_q[1] : stable_q;
        db_d     = (differ && !db_done) ? db_q + 1'b1 : '0;
        press    = db_done && sync_q[1];
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (press) begin
                    state_d = WAIT_RELEASE;
                    cause_d = 2'b01;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = REL_PERIPH;
                    cnt_d   = '0;
                end
            end
            REL_PERIPH: begin
                cnt_d = cnt_q + 1'b1;
                if (press) begin
                    state_d = WAIT_RELEASE;
                    cause_d = 2'b01;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(STAGE_DELAY - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (press) begin
                    state_d = WAIT_RELEASE;
                    cause_d = 2'b01;
                end else if (soft_reset_req) begin
                    state_d = HOLD;
                    cause_d = 2'b10;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (!stable_q) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            db_q     <= '0;
            sync_q   <= '0;
            stable_q <= 1'b0;
            cause_q  <= 2'b00;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            sync_q   <= {sync_q[0], button};
            stable_q <= stable_d;
            cause_q  <= cause_d;
            periph_q <= state_d != RUN && state_d != REL_PERIPH;
            cpu_q    <= state_d != RUN;
        end
    end
    assign periph_reset = periph_q;
    assign cpu_reset    = cpu_q;
    assign reset_cause  = cause_q;
    assign reset_active = cpu_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios plus random button/soft/reset traffic,
// checked every cycle against a countdown-based reference of the reset sequence.
module tb_reset_sequencer;
    localparam int HOLD  = 20;
    localparam int STAGE = 8;
    localparam int DEB   = 4;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       periph_reset, cpu_reset, reset_active;
    logic [1:0] reset_cause;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         bh0, bh1, m_stable, m_wait;
    int         m_run, m_pl, m_cl;
    logic [1:0] m_cause;
    reset_sequencer #(
        .HOLD_CYCLES(HOLD),
        .STAGE_DELAY(STAGE),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .button(button),
        .soft_reset_req(soft_reset_req),
        .periph_reset(periph_reset),
        .cpu_reset(cpu_reset),
        .reset_cause(reset_cause),
        .reset_active(reset_active)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask
    // Reference: periph/cpu release is a countdown of remaining edges from the sequence start.
    task automatic model_edge(input bit r, input bit b, input bit s);
        bit old_stable, press;
        if (r) begin
            bh0 = 0; bh1 = 0; m_stable = 0; m_run = 0; m_wait = 0;
            m_pl = HOLD; m_cl = HOLD + STAGE; m_cause = 2'b00;
        end else begin
            old_stable = m_stable;
            press = 0;
            if (bh1 != m_stable) begin
                m_run++;
                if (m_run == DEB) begin
                    m_stable = bh1;
                    m_run = 0;
                    press = bh1;
                end
            end else m_run = 0;
            bh1 = bh0;
            bh0 = b;
            if (m_wait) begin
                if (!old_stable) begin
                    m_wait = 0; m_pl = HOLD; m_cl = HOLD + STAGE;
                end
            end else if (press) begin
                m_wait = 1; m_cause = 2'b01;
            end else if (m_cl == 0 && s) begin
                m_pl = HOLD; m_cl = HOLD + STAGE; m_cause = 2'b10;
            end else begin
                if (m_pl > 0) m_pl--;
                if (m_cl > 0) m_cl--;
            end
        end
    endtask
    task automatic step(input bit r, input bit b, input bit s);
        bit mp, mc;
        reset = r;
        button = b;
        soft_reset_req = s;
        @(posedge clk);
        model_edge(r, b, s);
        #1;
        mp = m_wait || m_pl > 0;
        mc = m_wait || m_cl > 0;
        check("periph_reset", {1'b0, periph_reset}, {1'b0, mp});
        check("cpu_reset", {1'b0, cpu_reset}, {1'b0, mc});
        check("reset_active", {1'b0, reset_active}, {1'b0, mc});
        check("reset_cause", reset_cause, m_cause);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask
    initial begin
        int rl;
        bit b;
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        idle(40);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        idle(10);
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        idle(60);
        for (int i = 0; i < 100; i++) step(0, 1, 0);
        idle(60);
        step(0, 0, 1);
        idle(22);
        step(0, 0, 1);
        idle(40);
        for (int i = 1; i <= 10; i++) step(0, 1, i == 6);
        idle(60);
        step(0, 0, 1);
        idle(HOLD + 4);
        step(1, 1, 1);
        step(1, 0, 0);
        idle(40);
        rl = 0;
        b = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rl == 0) begin
                b = 1'($urandom_range(0, 1));
                rl = $urandom_range(1, 12);
            end
            rl--;
            step($urandom_range(0, 199) == 0, b, $urandom_range(0, 9) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
